// File: rtl/gesture_pixel_classifier.sv
// Counts foreground pixels per frame, classifies the count against a threshold
// table and debounces the class over STABLE_N consecutive equal frames.
module gesture_pixel_classifier #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int CNT_W    = 19,
    parameter int NUM_CLS  = 6,
    parameter int CLS_W    = 3,
    parameter int STABLE_N = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pix_valid,
    input  logic                       pix_bit,
    input  logic [9:0]                 xpos,
    input  logic [9:0]                 ypos,
    input  logic [NUM_CLS*CNT_W-1:0]   thr,
    output logic [CNT_W-1:0]           area_o,
    output logic [CLS_W-1:0]           class_o,
    output logic                       frame_done,
    output logic                       class_chg
);

    localparam logic [9:0]       X_LAST  = 10'(IMG_W - 1);
    localparam logic [9:0]       Y_LAST  = 10'(IMG_H - 1);
    localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};
    localparam logic [3:0]       RUN_MAX = 4'(STABLE_N);

    logic                 in_frame_reg;
    logic [CNT_W-1:0]     acc_reg;
    logic [CNT_W-1:0]     area_reg;
    logic [CLS_W-1:0]     raw_reg;
    logic                 frame_done_reg;
    logic [CLS_W-1:0]     cand_reg;
    logic [CLS_W-1:0]     cand_next;
    logic [3:0]           run_reg;
    logic [3:0]           run_next;
    logic [CLS_W-1:0]     class_reg;
    logic                 class_chg_reg;

    logic                 fs;
    logic                 fe;
    logic [CNT_W-1:0]     acc_plus;
    logic [NUM_CLS-1:0]   ge;
    logic [CLS_W-1:0]     raw_next;
    logic                 class_upd;

    assign fs = pix_valid && (xpos == 10'd0) && (ypos == 10'd0);
    assign fe = pix_valid && (xpos == X_LAST) && (ypos == Y_LAST);

    // Saturating add of the current pixel; also the final count on the FE cycle.
    assign acc_plus = (pix_bit && (acc_reg != ACC_MAX)) ? acc_reg + CNT_W'(1) : acc_reg;

    for (genvar gi = 0; gi < NUM_CLS; gi++) begin : g_thr
        assign ge[gi] = (acc_plus >= thr[gi*CNT_W +: CNT_W]);
    end

    always_comb begin
        raw_next = '0;
        for (int k = 0; k < NUM_CLS; k++) begin
            raw_next = raw_next + CLS_W'(ge[k]);
        end
    end

    always_comb begin
        cand_next = cand_reg;
        run_next  = run_reg;
        if (frame_done_reg) begin
            if (raw_reg == cand_reg) begin
                run_next = (run_reg >= RUN_MAX) ? RUN_MAX : run_reg + 4'd1;
            end else begin
                cand_next = raw_reg;
                run_next  = 4'd1;
            end
        end
    end

    assign class_upd = frame_done_reg && (run_next == RUN_MAX) && (cand_next != class_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame_reg   <= 1'b0;
            acc_reg        <= '0;
            area_reg       <= '0;
            raw_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (fs) begin
                in_frame_reg <= 1'b1;
                acc_reg      <= CNT_W'(pix_bit);
            end else if (fe && in_frame_reg) begin
                in_frame_reg   <= 1'b0;
                area_reg       <= acc_plus;
                raw_reg        <= raw_next;
                frame_done_reg <= 1'b1;
            end else if (pix_valid && in_frame_reg) begin
                acc_reg <= acc_plus;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_reg      <= '0;
            run_reg       <= '0;
            class_reg     <= '0;
            class_chg_reg <= 1'b0;
        end else begin
            cand_reg      <= cand_next;
            run_reg       <= run_next;
            class_chg_reg <= class_upd;
            if (class_upd) begin
                class_reg <= cand_next;
            end
        end
    end

    assign area_o     = area_reg;
    assign class_o    = class_reg;
    assign frame_done = frame_done_reg;
    assign class_chg  = class_chg_reg;

endmodule

// File: tb/tb_gesture_pixel_classifier.sv
// Bench for gesture_pixel_classifier: directed frame table, hand corner cases and
// randomized frames, all checked every cycle against a frame-level model.
module tb_gesture_pixel_classifier;

    localparam int IMG_W    = 32;
    localparam int IMG_H    = 16;
    localparam int CNT_W    = 8;
    localparam int NUM_CLS  = 6;
    localparam int CLS_W    = 3;
    localparam int STABLE_N = 3;
    localparam int MAXC     = (1 << CNT_W) - 1;
    localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
    localparam logic [9:0] Y_LAST = 10'(IMG_H - 1);

    logic                     clk;
    logic                     rst_n;
    logic                     pix_valid;
    logic                     pix_bit;
    logic [9:0]               xpos;
    logic [9:0]               ypos;
    logic [NUM_CLS*CNT_W-1:0] thr;
    logic [CNT_W-1:0]         area_o;
    logic [CLS_W-1:0]         class_o;
    logic                     frame_done;
    logic                     class_chg;

    gesture_pixel_classifier #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W),
        .NUM_CLS(NUM_CLS), .CLS_W(CLS_W), .STABLE_N(STABLE_N)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_bit(pix_bit),
        .xpos(xpos), .ypos(ypos), .thr(thr), .area_o(area_o), .class_o(class_o),
        .frame_done(frame_done), .class_chg(class_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int fd_cnt = 0;

    // Model state: frame membership, running count, expected registered outputs,
    // and the history of raw classes of completed frames since reset.
    int  thr_a[NUM_CLS];
    bit  m_in;
    int  m_cnt;
    int  m_raw;
    int  e_area;
    int  e_cls;
    bit  e_fd;
    bit  e_chg;
    int  hist[$];

    typedef struct {
        int ones;
        int exp_area;
        int exp_cls;
        bit exp_chg;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic int raw_of(input int a);
        int c = 0;
        for (int k = 0; k < NUM_CLS; k++) if (a >= thr_a[k]) c++;
        return c;
    endfunction

    function automatic bit stable_run(input int val);
        if (hist.size() < STABLE_N) return 1'b0;
        for (int i = 0; i < STABLE_N; i++)
            if (hist[hist.size() - 1 - i] != val) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load_thr();
        for (int k = 0; k < NUM_CLS; k++) thr[k*CNT_W +: CNT_W] = CNT_W'(thr_a[k]);
    endtask

    task automatic model_reset();
        m_in = 0; m_cnt = 0; m_raw = 0;
        e_area = 0; e_cls = 0; e_fd = 0; e_chg = 0;
        hist.delete();
    endtask

    task automatic step(input logic v, input logic b, input logic [9:0] x, input logic [9:0] y);
        int n_area = e_area;
        int n_raw  = m_raw;
        int n_cls  = e_cls;
        bit n_fd   = 1'b0;
        bit n_chg  = 1'b0;
        if (e_fd) begin
            hist.push_back(m_raw);
            if (hist.size() > 16) void'(hist.pop_front());
            if (stable_run(m_raw) && m_raw != e_cls) begin
                n_cls = m_raw;
                n_chg = 1'b1;
            end
        end
        if (v && x == 0 && y == 0) begin
            m_in = 1; m_cnt = int'(b);
        end else if (v && x == X_LAST && y == Y_LAST && m_in) begin
            n_area = sat(m_cnt + int'(b));
            n_raw  = raw_of(n_area);
            n_fd   = 1'b1;
            m_in   = 0;
        end else if (v && m_in) begin
            m_cnt = sat(m_cnt + int'(b));
        end
        pix_valid = v; pix_bit = b; xpos = x; ypos = y;
        @(posedge clk);
        #1;
        e_area = n_area; m_raw = n_raw; e_cls = n_cls; e_fd = n_fd; e_chg = n_chg;
        check("area_o", 32'(area_o), 32'(e_area));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("class_o", 32'(class_o), 32'(e_cls));
        check("class_chg", 32'(class_chg), 32'(e_chg));
        if (frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_area"}, 32'(area_o), 32'd0);
        check({nm, "_class"}, 32'(class_o), 32'd0);
        check({nm, "_fd"}, 32'(frame_done), 32'd0);
        check({nm, "_chg"}, 32'(class_chg), 32'd0);
    endtask

    // Asserts reset between edges with pixel activity (FS/FE coordinates) applied.
    task automatic reset_pulse(input int cyc);
        #2;
        rst_n = 1'b0;
        pix_valid = 1'b1; pix_bit = 1'b1; xpos = 10'd0; ypos = 10'd0;
        #1;
        check_zero("rst_async");
        for (int i = 0; i < cyc; i++) begin
            xpos = (i % 2 == 0) ? X_LAST : 10'd0;
            ypos = (i % 2 == 0) ? Y_LAST : 10'd0;
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input int n, input int nz, input int abort_at);
        int ones_left  = (n >= 2) ? n - 2 : 0;
        int zeros_left = nz;
        int idx        = 0;
        step(1'b1, n >= 1, 10'd0, 10'd0);
        while (ones_left + zeros_left > 0) begin
            logic bb;
            if ($urandom_range(0, 7) == 0) step(1'b0, 1'b1, X_LAST, Y_LAST);
            if (idx == abort_at) step(1'b1, 1'b1, 10'd0, 10'd0);
            if (zeros_left == 0) bb = 1'b1;
            else if (ones_left == 0) bb = 1'b0;
            else bb = 1'($urandom_range(0, 1));
            if (bb) ones_left--; else zeros_left--;
            step(1'b1, bb, 10'($urandom_range(1, IMG_W - 2)), 10'($urandom_range(0, IMG_H - 1)));
            idx++;
        end
        step(1'b1, n >= 2, X_LAST, Y_LAST);
    endtask

    initial begin
        tbl[0]  = '{100, 100, 0, 0};
        tbl[1]  = '{100, 100, 0, 0};
        tbl[2]  = '{100, 100, 3, 1};
        tbl[3]  = '{50,  50,  3, 0};
        tbl[4]  = '{130, 130, 3, 0};
        tbl[5]  = '{50,  50,  3, 0};
        tbl[6]  = '{130, 130, 3, 0};
        tbl[7]  = '{50,  50,  3, 0};
        tbl[8]  = '{300, 255, 3, 0};
        tbl[9]  = '{300, 255, 3, 0};
        tbl[10] = '{300, 255, 6, 1};
        tbl[11] = '{0,   0,   6, 0};

        thr_a = '{10, 40, 80, 120, 160, 200};
        load_thr();
        model_reset();
        rst_n = 1'b0;
        pix_valid = 1'b1; pix_bit = 1'b1; xpos = 10'd0; ypos = 10'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_zero("init_rst");
            xpos = X_LAST; ypos = Y_LAST;
        end
        #2;
        rst_n = 1'b1;

        // Activity before any FS, including a lone FE, must be ignored.
        step(1'b1, 1'b1, X_LAST, Y_LAST);
        step(1'b1, 1'b1, 10'd5, 10'd3);
        step(1'b0, 1'b1, 10'd0, 10'd0);
        check_zero("pre_fs");

        for (int i = 0; i < 12; i++) begin
            send_frame(tbl[i].ones, 10, -1);
            check($sformatf("tbl%0d_area", i), 32'(area_o), 32'(tbl[i].exp_area));
            check($sformatf("tbl%0d_fd", i), 32'(frame_done), 32'd1);
            step(1'b0, 1'b0, 10'd0, 10'd0);
            check($sformatf("tbl%0d_cls", i), 32'(class_o), 32'(tbl[i].exp_cls));
            check($sformatf("tbl%0d_chg", i), 32'(class_chg), 32'(tbl[i].exp_chg));
        end

        // Abort: FS reissued mid-frame; only the restarted frame completes.
        fd_cnt = 0;
        step(1'b1, 1'b1, 10'd0, 10'd0);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 10'd3, 10'd2);
        step(1'b1, 1'b1, 10'd0, 10'd0);
        for (int i = 0; i < 48; i++) step(1'b1, 1'b1, 10'd4, 10'd1);
        step(1'b1, 1'b1, X_LAST, Y_LAST);
        check("abort_area", 32'(area_o), 32'd50);
        check("abort_fd_count", 32'(fd_cnt), 32'd1);
        step(1'b0, 1'b0, 10'd0, 10'd0);

        // Lone FE after a completed frame.
        fd_cnt = 0;
        step(1'b1, 1'b1, X_LAST, Y_LAST);
        step(1'b0, 1'b0, 10'd0, 10'd0);
        check("lone_fe_fd_count", 32'(fd_cnt), 32'd0);

        // Reset mid-frame, then FE without FS, then a full 7-one frame.
        step(1'b1, 1'b1, 10'd0, 10'd0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 10'd2, 10'd2);
        reset_pulse(3);
        fd_cnt = 0;
        step(1'b1, 1'b1, X_LAST, Y_LAST);
        step(1'b0, 1'b0, 10'd0, 10'd0);
        check("rst_fe_fd_count", 32'(fd_cnt), 32'd0);
        check("rst_fe_area", 32'(area_o), 32'd0);
        send_frame(7, 5, -1);
        check("after_rst_area", 32'(area_o), 32'd7);
        check("after_rst_fd", 32'(frame_done), 32'd1);

        // Back-to-back frames: next FS at FE+1.
        send_frame(20, 3, -1);
        send_frame(30, 3, -1);
        check("b2b_area", 32'(area_o), 32'd30);
        step(1'b0, 1'b0, 10'd0, 10'd0);

        // Randomized frames with arbitrary (possibly unsorted) thresholds.
        for (int f = 0; f < 40; f++) begin
            int n  = $urandom_range(0, 300);
            int nz = $urandom_range(0, 40);
            int ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 100)) : -1;
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < NUM_CLS; k++) thr_a[k] = $urandom_range(0, MAXC);
                load_thr();
            end
            if ($urandom_range(0, 2) == 0) n = 40 + 40 * (f % 3);
            send_frame(n, nz, ab);
            repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)), X_LAST, Y_LAST);
        end
        step(1'b0, 1'b0, 10'd0, 10'd0);
        step(1'b0, 1'b0, 10'd0, 10'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
